// File: rtl/button_ram_arbiter.sv
// Two-master round-robin arbiter for the 32-bit x DEPTH single-port button RAM.
// Define BUTTON_RAM_ARB_FIXED_PRIO_EN for fixed priority, where m0 always wins.
module button_ram_arbiter #(
    parameter int DEPTH      = 5000,
    parameter int ADDR_W     = 13,
    parameter int MAX_CONSEC = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [3:0]        m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [31:0]       m0_writedata,
    output logic              m0_waitrequest,
    output logic [31:0]       m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [3:0]        m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [31:0]       m1_writedata,
    output logic              m1_waitrequest,
    output logic [31:0]       m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] ram_address,
    output logic [3:0]        ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [31:0]       ram_writedata,
    output logic              ram_clken,
    input  logic [31:0]       ram_readdata,
    input  logic              err_clr,
    output logic              err_oor
);
    // Handshake: a master's command is taken in the cycle its waitrequest is 0;
    // a read taken in cycle T returns readdatavalid/readdata in T+1.

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_t;

    owner_t      owner_q, owner_n;
    logic [3:0]  consec_q, consec_n;
    logic        pend_valid_q, pend_oor_q, err_oor_q;
    owner_t      pend_owner_q;

    logic        req0, req1, own_req, oth_req;
    logic        gnt;
    owner_t      gnt_sel;
    logic [ADDR_W-1:0] sel_addr;
    logic [3:0]  sel_be;
    logic [31:0] sel_wdata;
    logic        sel_read, sel_write;
    logic        in_range;
    logic        rd_accept;
    logic [31:0] rdata_mux;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    always_comb begin
        gnt      = 1'b0;
        gnt_sel  = owner_q;
        owner_n  = owner_q;
        consec_n = consec_q;
        own_req  = (owner_q == OWN_M0) ? req0 : req1;
        oth_req  = (owner_q == OWN_M0) ? req1 : req0;
        if (reset_n) begin
`ifdef BUTTON_RAM_ARB_FIXED_PRIO_EN
            if (req0) begin
                gnt     = 1'b1;
                gnt_sel = OWN_M0;
            end else if (req1) begin
                gnt     = 1'b1;
                gnt_sel = OWN_M1;
            end
`else
            // Owner keeps the RAM until its burst budget runs out while the other waits.
            if (own_req && ((consec_q < 4'(MAX_CONSEC)) || !oth_req)) begin
                gnt     = 1'b1;
                gnt_sel = owner_q;
            end else if (oth_req) begin
                gnt     = 1'b1;
                gnt_sel = (owner_q == OWN_M0) ? OWN_M1 : OWN_M0;
            end
`endif
        end
        if (gnt) begin
            if (gnt_sel == owner_q) begin
                consec_n = (consec_q >= 4'(MAX_CONSEC)) ? consec_q : consec_q + 4'd1;
            end else begin
                owner_n  = gnt_sel;
                consec_n = 4'd1;
            end
        end else begin
            consec_n = 4'd0;
        end
    end

    always_comb begin
        sel_addr  = (gnt_sel == OWN_M1) ? m1_address    : m0_address;
        sel_be    = (gnt_sel == OWN_M1) ? m1_byteenable : m0_byteenable;
        sel_wdata = (gnt_sel == OWN_M1) ? m1_writedata  : m0_writedata;
        sel_read  = (gnt_sel == OWN_M1) ? m1_read       : m0_read;
        sel_write = (gnt_sel == OWN_M1) ? m1_write      : m0_write;
    end

    assign in_range  = (32'(sel_addr) < 32'(DEPTH));
    // Read+write together is treated as a write, so no data is returned.
    assign rd_accept = gnt & sel_read & ~sel_write;

    assign ram_address    = gnt ? sel_addr  : '0;
    assign ram_byteenable = gnt ? sel_be    : '0;
    assign ram_writedata  = gnt ? sel_wdata : '0;
    assign ram_write      = gnt & sel_write;
    assign ram_chipselect = gnt & in_range;
    assign ram_clken      = reset_n;

    assign m0_waitrequest = ~(gnt && (gnt_sel == OWN_M0));
    assign m1_waitrequest = ~(gnt && (gnt_sel == OWN_M1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            owner_q      <= OWN_M0;
            consec_q     <= 4'd0;
            pend_valid_q <= 1'b0;
            pend_owner_q <= OWN_M0;
            pend_oor_q   <= 1'b0;
            err_oor_q    <= 1'b0;
        end else begin
            owner_q      <= owner_n;
            consec_q     <= consec_n;
            pend_valid_q <= rd_accept;
            pend_owner_q <= gnt_sel;
            pend_oor_q   <= ~in_range;
            if (gnt && !in_range) begin
                err_oor_q <= 1'b1;
            end else if (err_clr) begin
                err_oor_q <= 1'b0;
            end
        end
    end

    // Gating with reset_n cancels a return that was in flight when reset hit.
    assign m0_readdatavalid = reset_n & pend_valid_q & (pend_owner_q == OWN_M0);
    assign m1_readdatavalid = reset_n & pend_valid_q & (pend_owner_q == OWN_M1);
    assign rdata_mux        = pend_oor_q ? 32'h0 : ram_readdata;
    assign m0_readdata      = m0_readdatavalid ? rdata_mux : 32'h0;
    assign m1_readdata      = m1_readdatavalid ? rdata_mux : 32'h0;
    assign err_oor          = err_oor_q;

endmodule

// File: doc/button_ram_arbiter.md
Name: button_ram_arbiter

Overview:
- Two-master arbiter that shares the single-port 32-bit x 5000-word on-chip button RAM between two Avalon-MM-style requesters, for example the CPU data port and a DMA/scan engine.
- Issues at most one command per cycle to the RAM.
- Arbitration is round-robin with a bounded-burst hold.
- Returns read data with fixed 1-cycle latency via readdatavalid.
- Drops out-of-range accesses and flags them.

Parameters:
- DEPTH, 5000, number of valid RAM words; any address >= DEPTH is out of range.
- ADDR_W, 13, address width in words.
- MAX_CONSEC, 4, maximum consecutive grants to one master while the other is requesting (range 1..15).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous reset, active-low.
- m0_address / m1_address  in  ADDR_W  word address.
- m0_byteenable / m1_byteenable  in  4  byte lanes.
- m0_read / m1_read  in  1  read request.
- m0_write / m1_write  in  1  write request.
- m0_writedata / m1_writedata  in  32  write data.
- m0_waitrequest / m1_waitrequest  out  1  high = command not accepted this cycle.
- m0_readdata / m1_readdata  out  32  read data.
- m0_readdatavalid / m1_readdatavalid  out  1  read data valid.
- ram_address  out  ADDR_W  to RAM.
- ram_byteenable  out  4  to RAM.
- ram_chipselect  out  1  to RAM.
- ram_write  out  1  to RAM.
- ram_writedata  out  32  to RAM.
- ram_clken  out  1  RAM clock enable.
- ram_readdata  in  32  RAM q (valid the cycle after the address is presented).
- err_clr  in  1  clears err_oor.
- err_oor  out  1  sticky out-of-range flag.

Behaviour:
- Reset, sampled on a clk edge while reset_n=0:
  - owner=m0, consec=0, pending read owner=none, err_oor=0.
  - While reset_n=0: both waitrequest=1, ram_chipselect=0, ram_write=0, readdatavalid=0, ram_clken=0.
  - ram_clken=1 from the first cycle after reset_n goes high.
- Request definitions:
  - reqN = mN_read | mN_write.
  - If read and write are both high, the request is a write; no readdatavalid follows.
- Grant (combinational, each cycle):
  - If owner requests and (consec < MAX_CONSEC or the other master is idle): grant owner.
  - Else if the other master requests: grant other.
  - Else: no grant.
- Grant/consec update:
  - Grant to the same owner: consec increments, saturating at MAX_CONSEC.
  - Grant to the other master: that master becomes owner and consec=1.
  - No grant: owner held, consec=0.
- Granted master:
  - Sees waitrequest=0 in cycle T and its command is forwarded combinationally to the ram_* outputs in T.
  - ram_chipselect=1 only for an in-range command.
  - ram_write=1 for writes.
- Non-granted requester: waitrequest=1. Idle masters also see waitrequest=1.
- Read latency:
  - A read accepted in T produces mN_readdatavalid=1 with mN_readdata=ram_readdata in T+1, tracked by a registered pending-owner tag.
  - Back-to-back reads are fully pipelined: 1 per cycle, including alternating masters.
  - mN_readdata=0 when readdatavalid=0.
- Out of range (address >= DEPTH):
  - The command is accepted (waitrequest=0) and counts as a grant, but ram_chipselect=0.
  - Write: dropped.
  - Read: readdatavalid=1 in T+1 with readdata=32'h0.
  - err_oor is set at the end of T.
- err_oor:
  - Cleared by err_clr.
  - If set and clear occur in the same cycle, set wins.
- Write followed by read of the same address in the next cycle returns the new data (RAM write completes at the T edge).
- Reset mid-operation: a pending readdatavalid is cancelled, and the RAM contents are untouched.

Optional Feature:
- BUTTON_RAM_ARB_FIXED_PRIO_EN.
- Defined:
  - Fixed priority, m0 always wins when requesting.
  - MAX_CONSEC and the consec counter are unused, so m1 can starve.
- Undefined (default): round-robin with bounded burst as above.

Test Plan:
- Reset then m0 write addr 0x0010 data 0xDEADBEEF be=4'hF, next cycle m0 read 0x0010 -> m0_waitrequest=0 both cycles; m0_readdatavalid=1 one cycle later with 0xDEADBEEF; m1 outputs quiet.
- Partial write: m1 writes 0x11223344 be=4'hF, then 0x0000AA00 be=4'b0010 to addr 0x0100; read back -> 0x1122AA44.
- Both masters hold continuous reads from reset, MAX_CONSEC=4:
  - Grants are m0 x4, m1 x4, m0 x4, and so on.
  - Each readdatavalid arrives exactly 1 cycle after its grant to the correct master.
  - Waitrequest=1 on the loser.
- m0 read addr 5000 (0x1388) -> accepted, ram_chipselect=0, m0_readdata=0 with readdatavalid next cycle, err_oor=1; err_clr pulse -> err_oor=0; simultaneous OOR write + err_clr -> err_oor stays 1.
- m0 read accepted, reset_n low in the following cycle -> no readdatavalid, waitrequest=1 both, ram_clken=0; after release, ram_clken=1 and first access behaves normally.
- With BUTTON_RAM_ARB_FIXED_PRIO_EN: both request continuously for 10 cycles -> m0 granted all 10, m1_waitrequest=1 throughout.
